led_blink_multi: RTL and testbench
==================================

// Module: led_blink_multi
// PURPOSE
//   Parametrised multi-channel LED blinker; generalises the single-output blink block.
//   Each channel has a run-time mode (OFF/ON/BLINK/ONESHOT) and a half-period, loaded
//   over a one-cycle config write strobe. A global restart phase-aligns channels.
//   Sits between the board-control register logic and the LED pins.
// PARAMETERS
//   NUM_CH      4        number of LED channels (1..16)
//   CNT_W       24       width of per-channel period/counter
//   DEF_PERIOD  24'd5000000  half-period loaded at reset (cycles)
// PORTS
//   clk          in   1               system clock, rising edge
//   rst_n        in   1               asynchronous, active-low reset
//   cfg_we       in   1               config write strobe, one cycle
//   cfg_ch       in   $clog2(NUM_CH)+1  target channel index
//   cfg_mode     in   2               00 OFF, 01 ON, 10 BLINK, 11 ONESHOT
//   cfg_period   in   CNT_W           half-period / on-time in cycles
//   sync_restart in   1               realign all BLINK channels
//   led          out  NUM_CH          LED drive, 1 = lit
//   done         out  NUM_CH          one-cycle pulse when a ONESHOT completes
//   cfg_err      out  1               one-cycle pulse on write to invalid channel
// BEHAVIOUR
//   - Reset (async assert, sync release): mode=OFF, period=DEF_PERIOD, cnt=0, led=0,
//     done=0, cfg_err=0 for all channels.
//   - Effective period Pe = (period==0) ? 1 : period. All outputs registered.
//   - Config write (cfg_we=1, cfg_ch<NUM_CH): on that edge mode<=cfg_mode,
//     period<=cfg_period, cnt<=0, led<=(cfg_mode!=OFF). New LED level visible in cycle
//     after the strobe (latency 1).
//   - cfg_ch>=NUM_CH with cfg_we: no state change; cfg_err=1 for next cycle.
//   - OFF: led=0, cnt held 0. ON: led=1, cnt held 0.
//   - BLINK: cnt increments each cycle; at cnt==Pe-1: cnt<=0, led<=~led.
//     LED high Pe cycles, low Pe cycles, repeating; first high phase starts at write.
//   - ONESHOT: led=1 for Pe cycles; at cnt==Pe-1: led<=0, mode<=OFF, done[ch]=1 for one
//     cycle. Re-writing ONESHOT during the pulse restarts it (cnt=0), no done.
//   - sync_restart=1: every BLINK channel cnt<=0, led<=1; other modes unaffected.
//   - Priority per channel, same cycle: config write > sync_restart > terminal count.
//     Write coinciding with terminal count: write wins, no toggle, no done pulse.
//   - Counter never exceeds Pe-1; period change only via write (takes effect at once).
//   - rst_n asserted mid-operation: all state returns to reset values immediately.
// CONFIGURATION
//   LED_PWM_EN defined: adds input bright[7:0] and an 8-bit free-running pwm_cnt
//     (reset 0, wraps 255->0). led[i] = led_q[i] & (pwm_cnt < bright); bright=0 -> dark,
//     bright=255 -> lit 255/256 cycles. Gating applies in all modes; done unaffected.
//     led is then combinational from registers (no extra latency).
//   LED_PWM_EN undefined: bright port absent, led = led_q directly.
// TESTING
//   1. Reset, write ch0 BLINK P=3 at cycle 0 -> led[0]=1 cycles 1-3, 0 cycles 4-6, 1 7-9.
//   2. ch1 ONESHOT P=5 -> led[1]=1 for 5 cycles, done[1]=1 on cycle led falls, then OFF.
//   3. ch2 BLINK P=0 -> led[2] toggles every cycle; write ON -> led[2]=1 steady next cycle.
//   4. cfg_ch=NUM_CH with cfg_we -> cfg_err=1 one cycle, all led/mode unchanged.
//   5. ch0 P=4, ch1 P=6 BLINK, pulse sync_restart -> both led=1 next cycle, cnt=0, in phase;
//      write ch0 same cycle as sync -> ch0 takes write values.
//   6. rst_n low mid-BLINK -> led=0 asynchronously; LED_PWM_EN, ON, bright=64 -> 64/256 lit.

Source files
------------

// File: rtl/led_blink_multi.sv
// ---------------------------------------------------------------------------
// led_blink_multi
//   Multi-channel LED blinker that sits between the board-control register
//   logic and the LED pins. Each channel has a run-time mode and a half-period.
//   Both are loaded by a one-cycle config write strobe. A global restart
//   brings every BLINK channel back into phase.
//
//   Modes: 00 OFF, 01 ON, 10 BLINK, 11 ONESHOT.
//   A period of 0 is treated as 1, so the effective period Pe is never zero.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous, active-low reset
//   cfg_we       in   config write strobe, one cycle
//   cfg_ch       in   target channel index ($clog2(NUM_CH)+1 bits)
//   cfg_mode     in   channel mode
//   cfg_period   in   half-period / on-time in cycles (CNT_W bits)
//   sync_restart in   realign all BLINK channels (cnt=0, led=1)
//   bright       in   8-bit brightness; present only with LED_PWM_EN
//   led          out  LED drive per channel, 1 = lit
//   done         out  one-cycle pulse when a ONESHOT completes
//   cfg_err      out  one-cycle pulse on a write to an invalid channel
//
// Build option
//   LED_PWM_EN   adds the bright input and an 8-bit free-running PWM counter.
//                led is then gated by (pwm_cnt < bright).
// ---------------------------------------------------------------------------
module led_blink_multi #(
    parameter int              NUM_CH     = 4,
    parameter int              CNT_W      = 24,
    parameter logic [CNT_W-1:0] DEF_PERIOD = 24'd5000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_CH):0]    cfg_ch,
    input  logic [1:0]                 cfg_mode,
    input  logic [CNT_W-1:0]           cfg_period,
    input  logic                       sync_restart,
`ifdef LED_PWM_EN
    input  logic [7:0]                 bright,
`endif
    output logic [NUM_CH-1:0]          led,
    output logic [NUM_CH-1:0]          done,
    output logic                       cfg_err
);

    localparam int CH_W = $clog2(NUM_CH) + 1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    logic [NUM_CH-1:0] w_led_q;
    logic [NUM_CH-1:0] w_done_q;
    logic              r_cfg_err;

    // A write to a channel that does not exist only raises the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && (cfg_ch >= CH_W'(NUM_CH));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            mode_t            r_mode;
            logic [CNT_W-1:0] r_period;
            logic [CNT_W-1:0] r_cnt;
            logic             r_led;
            logic             r_done;

            mode_t            w_mode_nxt;
            logic [CNT_W-1:0] w_period_nxt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic             w_led_nxt;
            logic             w_done_nxt;
            logic             w_wr;
            logic [CNT_W-1:0] w_term;

            assign w_wr = cfg_we && (cfg_ch == CH_W'(g));
            // Terminal count is Pe-1. A zero period behaves like a period of 1.
            assign w_term = (r_period == '0) ? '0 : (r_period - 1'b1);

            // Priority: config write, then sync_restart, then terminal count.
            always_comb begin
                w_mode_nxt   = r_mode;
                w_period_nxt = r_period;
                w_cnt_nxt    = r_cnt;
                w_led_nxt    = r_led;
                w_done_nxt   = 1'b0;
                if (w_wr) begin
                    w_mode_nxt   = mode_t'(cfg_mode);
                    w_period_nxt = cfg_period;
                    w_cnt_nxt    = '0;
                    w_led_nxt    = (cfg_mode != MODE_OFF);
                end else if (sync_restart && (r_mode == MODE_BLINK)) begin
                    w_cnt_nxt = '0;
                    w_led_nxt = 1'b1;
                end else begin
                    case (r_mode)
                        MODE_OFF: begin
                            w_cnt_nxt = '0;
                            w_led_nxt = 1'b0;
                        end
                        MODE_ON: begin
                            w_cnt_nxt = '0;
                            w_led_nxt = 1'b1;
                        end
                        MODE_BLINK: begin
                            if (r_cnt == w_term) begin
                                w_cnt_nxt = '0;
                                w_led_nxt = ~r_led;
                            end else begin
                                w_cnt_nxt = r_cnt + 1'b1;
                            end
                        end
                        MODE_ONESHOT: begin
                            if (r_cnt == w_term) begin
                                w_cnt_nxt  = '0;
                                w_led_nxt  = 1'b0;
                                w_mode_nxt = MODE_OFF;
                                w_done_nxt = 1'b1;
                            end else begin
                                w_cnt_nxt = r_cnt + 1'b1;
                            end
                        end
                        default: begin
                            w_cnt_nxt = '0;
                            w_led_nxt = 1'b0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mode   <= MODE_OFF;
                    r_period <= DEF_PERIOD;
                    r_cnt    <= '0;
                    r_led    <= 1'b0;
                    r_done   <= 1'b0;
                end else begin
                    r_mode   <= w_mode_nxt;
                    r_period <= w_period_nxt;
                    r_cnt    <= w_cnt_nxt;
                    r_led    <= w_led_nxt;
                    r_done   <= w_done_nxt;
                end
            end

            assign w_led_q[g]  = r_led;
            assign w_done_q[g] = r_done;
        end
    endgenerate

`ifdef LED_PWM_EN
    logic [7:0] r_pwm_cnt;
    logic       w_pwm_on;

    // Free-running; wraps 255 -> 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= 8'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // bright=0 never lights; bright=255 lights 255 of every 256 cycles.
    assign w_pwm_on = (r_pwm_cnt < bright);
    assign led      = w_led_q & {NUM_CH{w_pwm_on}};
`else
    assign led      = w_led_q;
`endif

    assign done    = w_done_q;
    assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_led_blink_multi.sv
module tb_led_blink_multi;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [23:0] cfg_period;
    logic        sync_restart;
`ifdef LED_PWM_EN
    logic [7:0]  bright;
`endif
    logic [3:0]  led;
    logic [3:0]  done;
    logic        cfg_err;

    int checks;
    int errors;

    led_blink_multi #(
        .NUM_CH    (4),
        .CNT_W     (24),
        .DEF_PERIOD(24'd5000000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_mode    (cfg_mode),
        .cfg_period  (cfg_period),
        .sync_restart(sync_restart),
`ifdef LED_PWM_EN
        .bright      (bright),
`endif
        .led         (led),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] ch, input logic [1:0] mode, input logic [23:0] per);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_mode   = mode;
        cfg_period = per;
        tick();
        cfg_we     = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        cfg_we       = 1'b0;
        cfg_ch       = 3'd0;
        cfg_mode     = 2'd0;
        cfg_period   = 24'd0;
        sync_restart = 1'b0;
`ifdef LED_PWM_EN
        bright       = 8'd255;
`endif
        tick();
        tick();
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_cfg_err", 32'(cfg_err), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("idle_led", 32'(led), 32'h0);

`ifndef LED_PWM_EN
        // ch0 BLINK P=3: high cycles 1-3, low 4-6, high 7-9
        wr(3'd0, 2'b10, 24'd3);
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("blink3_c%0d", k), 32'(led[0]), 32'((((k - 1) / 3) % 2) == 0));
            tick();
        end

        // ch0 back to OFF
        wr(3'd0, 2'b00, 24'd3);
        chk("ch0_off", 32'(led[0]), 32'h0);

        // ch1 ONESHOT P=5
        wr(3'd1, 2'b11, 24'd5);
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("oneshot_led_c%0d", k), 32'(led[1]), 32'h1);
            chk($sformatf("oneshot_done_c%0d", k), 32'(done[1]), 32'h0);
            tick();
        end
        chk("oneshot_fall_led", 32'(led[1]), 32'h0);
        chk("oneshot_done_pulse", 32'(done), 32'b0010);
        tick();
        chk("oneshot_done_clear", 32'(done[1]), 32'h0);
        chk("oneshot_off_led", 32'(led[1]), 32'h0);

        // ch2 BLINK P=0 toggles every cycle, then ON
        wr(3'd2, 2'b10, 24'd0);
        chk("p0_c1", 32'(led[2]), 32'h1);
        tick();
        chk("p0_c2", 32'(led[2]), 32'h0);
        tick();
        chk("p0_c3", 32'(led[2]), 32'h1);
        tick();
        chk("p0_c4", 32'(led[2]), 32'h0);
        wr(3'd2, 2'b01, 24'd9);
        chk("on_c1", 32'(led[2]), 32'h1);
        tick();
        chk("on_c2", 32'(led[2]), 32'h1);

        // invalid channel write
        wr(3'd4, 2'b01, 24'd1);
        chk("bad_ch_err", 32'(cfg_err), 32'h1);
        chk("bad_ch_led", 32'(led), 32'b0100);
        tick();
        chk("bad_ch_err_clear", 32'(cfg_err), 32'h0);
        chk("bad_ch_led_hold", 32'(led), 32'b0100);

        // ch0 P=4, ch1 P=6 BLINK, then sync_restart
        wr(3'd0, 2'b10, 24'd4);
        wr(3'd1, 2'b10, 24'd6);
        tick();
        tick();
        tick();
        chk("presync_led", 32'(led), 32'b0110);
        sync_restart = 1'b1;
        tick();
        sync_restart = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("sync_ch0_c%0d", k), 32'(led[0]), 32'((((k - 1) / 4) % 2) == 0));
            chk($sformatf("sync_ch1_c%0d", k), 32'(led[1]), 32'((((k - 1) / 6) % 2) == 0));
            chk($sformatf("sync_ch2_c%0d", k), 32'(led[2]), 32'h1);
            if (k < 8) tick();
        end

        // write ch0 ONESHOT P=2 in the same cycle as sync_restart
        sync_restart = 1'b1;
        cfg_we       = 1'b1;
        cfg_ch       = 3'd0;
        cfg_mode     = 2'b11;
        cfg_period   = 24'd2;
        tick();
        sync_restart = 1'b0;
        cfg_we       = 1'b0;
        chk("syncwr_c1", 32'(led[1:0]), 32'b11);
        tick();
        chk("syncwr_c2", 32'(led[1:0]), 32'b11);
        chk("syncwr_c2_done", 32'(done[0]), 32'h0);
        tick();
        chk("syncwr_c3_led", 32'(led[1:0]), 32'b10);
        chk("syncwr_c3_done", 32'(done[0]), 32'h1);

        // ch3 ONESHOT P=2 rewritten on its terminal cycle: restarts, no done
        wr(3'd3, 2'b11, 24'd2);
        tick();
        wr(3'd3, 2'b11, 24'd2);
        chk("retrig_led", 32'(led[3]), 32'h1);
        chk("retrig_no_done", 32'(done[3]), 32'h0);
        tick();
        chk("retrig_c2_led", 32'(led[3]), 32'h1);
        tick();
        chk("retrig_fall_led", 32'(led[3]), 32'h0);
        chk("retrig_done", 32'(done[3]), 32'h1);

        // asynchronous reset in the middle of BLINK
        wr(3'd1, 2'b10, 24'd3);
        tick();
        chk("prerst_led1", 32'(led[1]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(led), 32'h0);
        chk("async_rst_done", 32'(done), 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_led", 32'(led), 32'h0);
        tick();
        chk("post_rst_led2", 32'(led), 32'h0);
`else
        begin
            int lit;
            bright = 8'd64;
            wr(3'd0, 2'b01, 24'd1);
            lit = 0;
            for (int k = 0; k < 256; k++) begin
                if (led[0]) lit++;
                tick();
            end
            chk("pwm_64", 32'(lit), 32'd64);
            bright = 8'd0;
            #1;
            chk("pwm_dark", 32'(led), 32'h0);
            rst_n = 1'b0;
            #1;
            chk("pwm_rst", 32'(led), 32'h0);
            rst_n = 1'b1;
            tick();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
